mac_lane_array: RTL and testbench

- Parametrised multi-lane successor to the single-channel MAC.
- LANES independent channels each compute a block dot product: result = sum over k of sample[k]*coeff[k], for k = 0..num_taps-1.
- Coefficients live in an on-block register bank and are reused for every block, so no coefficient redo/reload is needed.
- Samples enter and results leave on valid/ready handshakes. The block sits between the sample FIFO and the downstream result consumer.

---
 rtl/mac_pkg.sv | 24 ++
 rtl/mac_lane.sv | 62 ++++++
 rtl/mac_lane_array.sv | 163 ++++++++++++++++
 tb/tb_mac_lane_array.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the multi-lane block MAC.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_LINES = 4;
    localparam int DEF_LANES      = 4;

    // Full product plus one bit per doubling of the tap count never overflows.
    function automatic int acc_width(input int data_width, input int addr_lines);
        return 2 * data_width + addr_lines;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One channel: registered product, sign/zero extension and clearable accumulator.
module mac_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 68
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  load_i,
    input  logic                  signed_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic [DATA_WIDTH-1:0] coeff_i,
    input  logic                  clr_i,
    input  logic                  add_i,
    output logic [ACC_WIDTH-1:0]  acc_o
);

    localparam int PW  = 2 * DATA_WIDTH;
    localparam int EXT = ACC_WIDTH - PW;

    logic [PW-1:0]        a_ext_s;
    logic [PW-1:0]        b_ext_s;
    logic [PW-1:0]        prod_d;
    logic [PW-1:0]        prod_q;
    logic                 prod_signed_q;
    logic [ACC_WIDTH-1:0] prod_ext_s;
    logic [ACC_WIDTH-1:0] acc_q;

    // Operands are widened first so the low 2*DATA_WIDTH bits of the product are exact in both modes.
    always_comb begin
        if (signed_i) begin
            a_ext_s = {{DATA_WIDTH{sample_i[DATA_WIDTH-1]}}, sample_i};
            b_ext_s = {{DATA_WIDTH{coeff_i[DATA_WIDTH-1]}}, coeff_i};
        end else begin
            a_ext_s = {{DATA_WIDTH{1'b0}}, sample_i};
            b_ext_s = {{DATA_WIDTH{1'b0}}, coeff_i};
        end
        prod_d     = a_ext_s * b_ext_s;
        prod_ext_s = {{EXT{prod_signed_q & prod_q[PW-1]}}, prod_q};
    end

    // Product stage on the accept edge, accumulate one edge later.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prod_q        <= '0;
            prod_signed_q <= 1'b0;
            acc_q         <= '0;
        end else begin
            if (load_i) begin
                prod_q        <= prod_d;
                prod_signed_q <= signed_i;
            end
            if (clr_i) begin
                acc_q <= '0;
            end else if (add_i) begin
                acc_q <= acc_q + prod_ext_s;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mac_lane_array.sv
// LANES parallel block dot-product channels sharing one FSM, tap counter and coefficient bank.
module mac_lane_array
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_LINES = DEF_ADDR_LINES,
    parameter int LANES      = DEF_LANES,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_LINES)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [ADDR_LINES:0]         cfg_taps_i,
    input  logic                        cfg_signed_i,
    input  logic                        coeff_wr_en_i,
    input  logic [ADDR_LINES-1:0]       coeff_addr_i,
    input  logic [LANES*DATA_WIDTH-1:0] coeff_data_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [LANES*DATA_WIDTH-1:0] s_data_i,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [LANES*ACC_WIDTH-1:0]  m_data_o,
    output logic                        busy_o,
    output logic                        cfg_err_o
);

    localparam int TAP_W = ADDR_LINES + 1;
    localparam int DEPTH = 2 ** ADDR_LINES;
    localparam logic [TAP_W-1:0] MAX_TAPS = TAP_W'(DEPTH);
    localparam logic [TAP_W-1:0] ONE_TAP  = TAP_W'(1);

    state_e                      state_q, state_d;
    logic [TAP_W-1:0]            taps_q, taps_eff_s, cnt_q;
    logic                        signed_q, flush_q, add_q, cfg_err_q;
    logic                        s_ready_q, s_ready_d, m_valid_q, m_valid_d, busy_q, busy_d;
    logic                        accept_s, last_s, start_s, lane_signed_s;
    logic [ADDR_LINES-1:0]       rd_addr_s;
    logic [LANES*DATA_WIDTH-1:0] coeff_q [DEPTH];
    logic [LANES*DATA_WIDTH-1:0] coeff_row_s;
    logic [LANES*ACC_WIDTH-1:0]  acc_s;

    // Zero taps only races in when cfg drops in the cycle ready was already up; treat it as one tap.
    always_comb begin
        if (cfg_taps_i > MAX_TAPS) begin
            taps_eff_s = MAX_TAPS;
        end else if (cfg_taps_i == '0) begin
            taps_eff_s = ONE_TAP;
        end else begin
            taps_eff_s = cfg_taps_i;
        end
        accept_s = s_valid_i & s_ready_q;
        start_s  = accept_s & (state_q == IDLE);
        last_s   = (cnt_q == (taps_q - ONE_TAP));
        if (state_q == IDLE) begin
            rd_addr_s     = '0;
            lane_signed_s = cfg_signed_i;
        end else begin
            rd_addr_s     = cnt_q[ADDR_LINES-1:0];
            lane_signed_s = signed_q;
        end
        coeff_row_s = coeff_q[rd_addr_s];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_s) state_d = (taps_eff_s == ONE_TAP) ? FLUSH : ACCUM;
                     else          state_d = IDLE;
            ACCUM:   if (accept_s && last_s) state_d = FLUSH;
                     else                    state_d = ACCUM;
            FLUSH:   if (flush_q) state_d = HOLD;
                     else         state_d = FLUSH;
            HOLD:    if (m_ready_i) state_d = IDLE;
                     else           state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so ready never follows s_valid_i combinationally.
    always_comb begin
        busy_d    = (state_d != IDLE);
        m_valid_d = (state_d == HOLD);
        case (state_d)
            IDLE:    s_ready_d = (cfg_taps_i != '0);
            ACCUM:   s_ready_d = 1'b1;
            default: s_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            busy_q    <= busy_d;
        end
    end

    // Block configuration, tap counter, pipeline drain tracking and the sticky error.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            taps_q    <= '0;
            signed_q  <= 1'b0;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            add_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            if (start_s) begin
                taps_q   <= taps_eff_s;
                signed_q <= cfg_signed_i;
                cnt_q    <= ONE_TAP;
            end else if ((state_q == ACCUM) && accept_s && !last_s) begin
                cnt_q <= cnt_q + ONE_TAP;
            end
            flush_q <= (state_q == FLUSH);
            add_q   <= accept_s;
            if (coeff_wr_en_i && (state_q != IDLE)) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                coeff_q[i] <= '0;
            end
        end else if (coeff_wr_en_i && (state_q == IDLE)) begin
            coeff_q[coeff_addr_i] <= coeff_data_i;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .load_i   (accept_s),
            .signed_i (lane_signed_s),
            .sample_i (s_data_i[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH]),
            .coeff_i  (coeff_row_s[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH]),
            .clr_i    (start_s),
            .add_i    (add_q),
            .acc_o    (acc_s[lane_lsb(l, ACC_WIDTH) +: ACC_WIDTH])
        );
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign busy_o    = busy_q;
    assign cfg_err_o = cfg_err_q;
    assign m_data_o  = acc_s;

endmodule

// File: tb/tb_mac_lane_array.sv
// Directed scoreboard bench for mac_lane_array with DATA_WIDTH=8, LANES=2, ADDR_LINES=2.
module tb_mac_lane_array;

    localparam int DW  = 8;
    localparam int AL  = 2;
    localparam int LN  = 2;
    localparam int ACC = 2 * DW + AL;

    logic            clk;
    logic            rstn;
    logic [AL:0]     cfg_taps;
    logic            cfg_signed;
    logic            coeff_wr_en;
    logic [AL-1:0]   coeff_addr;
    logic [LN*DW-1:0] coeff_data;
    logic            s_valid;
    logic            s_ready_o;
    logic [LN*DW-1:0] s_data;
    logic            m_valid_o;
    logic            m_ready;
    logic [LN*ACC-1:0] m_data_o;
    logic            busy_o;
    logic            cfg_err_o;

    int total = 0;
    int bad   = 0;
    logic [LN*ACC-1:0] exp_q [$];
    logic [LN*ACC-1:0] held;

    mac_lane_array #(
        .DATA_WIDTH (DW),
        .ADDR_LINES (AL),
        .LANES      (LN)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .cfg_taps_i    (cfg_taps),
        .cfg_signed_i  (cfg_signed),
        .coeff_wr_en_i (coeff_wr_en),
        .coeff_addr_i  (coeff_addr),
        .coeff_data_i  (coeff_data),
        .s_valid_i     (s_valid),
        .s_ready_o     (s_ready_o),
        .s_data_i      (s_data),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready),
        .m_data_o      (m_data_o),
        .busy_o        (busy_o),
        .cfg_err_o     (cfg_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wcoef(input logic [AL-1:0] a, input logic [DW-1:0] c1, input logic [DW-1:0] c0);
        coeff_addr  = a;
        coeff_data  = {c1, c0};
        coeff_wr_en = 1'b1;
        @(negedge clk);
        coeff_wr_en = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] s1, input logic [DW-1:0] s0);
        int n = 0;
        s_data  = {s1, s0};
        s_valid = 1'b1;
        while (!s_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 64'(s_ready_o), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!m_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(m_valid_o), 64'd1);
    endtask

    task automatic recv(input string tag);
        logic [LN*ACC-1:0] e;
        wait_valid(tag);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk(tag, 64'(m_data_o), 64'(e));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk({tag, "_drop"}, 64'(m_valid_o), 64'd0);
    endtask

    initial begin
        clk = 1'b0; rstn = 1'b0; cfg_taps = 3'd3; cfg_signed = 1'b0;
        coeff_wr_en = 1'b0; coeff_addr = '0; coeff_data = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready_o), 64'd0);
        chk("rst_m_valid", 64'(m_valid_o), 64'd0);
        chk("rst_m_data",  64'(m_data_o),  64'd0);
        chk("rst_busy",    64'(busy_o),    64'd0);
        chk("rst_cfg_err", 64'(cfg_err_o), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(s_ready_o), 64'd1);

        // Scenario 1: unsigned, 3 taps, no gaps.
        wcoef(2'd0, 8'd4, 8'd1); wcoef(2'd1, 8'd5, 8'd2); wcoef(2'd2, 8'd6, 8'd3);
        exp_q.push_back({18'd14, 18'd6});
        send(8'd2, 8'd1);
        chk("t1_busy", 64'(busy_o), 64'd1);
        send(8'd0, 8'd1);
        send(8'd1, 8'd1);
        chk("t1_lat0", 64'(m_valid_o), 64'd0);
        @(negedge clk);
        chk("t1_lat1", 64'(m_valid_o), 64'd0);
        @(negedge clk);
        chk("t1_lat2", 64'(m_valid_o), 64'd1);
        recv("t1");

        // Scenario 2: signed then unsigned on the same data.
        cfg_signed = 1'b1; cfg_taps = 3'd2;
        wcoef(2'd0, 8'hFF, 8'hFF); wcoef(2'd1, 8'h7F, 8'h7F);
        exp_q.push_back({18'h3FF80, 18'd1});
        send(8'h01, 8'h80); send(8'hFF, 8'hFF);
        recv("t2_signed");
        cfg_signed = 1'b0;
        exp_q.push_back({18'd32640, 18'd65025});
        send(8'h01, 8'h80); send(8'hFF, 8'hFF);

        // Scenario 3: backpressure on the unsigned result.
        wait_valid("t3");
        held = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        for (int i = 0; i < 5; i++) begin
            chk("t3_data_hold",  64'(m_data_o),  64'(held));
            chk("t3_ready_low",  64'(s_ready_o), 64'd0);
            chk("t3_valid_hold", 64'(m_valid_o), 64'd1);
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("t3_valid_drop", 64'(m_valid_o), 64'd0);
        chk("t3_ready_back", 64'(s_ready_o), 64'd1);
        chk("t3_idle",       64'(busy_o),    64'd0);

        // Scenario 4: bubbles and cfg changes mid-block.
        cfg_taps = 3'd3;
        wcoef(2'd0, 8'd4, 8'd1); wcoef(2'd1, 8'd5, 8'd2); wcoef(2'd2, 8'd6, 8'd3);
        exp_q.push_back({18'd14, 18'd6});
        send(8'd2, 8'd1);
        @(negedge clk);
        cfg_taps = 3'd1; cfg_signed = 1'b1;
        send(8'd0, 8'd1);
        @(negedge clk);
        cfg_taps = 3'd7;
        send(8'd1, 8'd1);
        cfg_taps = 3'd3; cfg_signed = 1'b0;
        recv("t4");

        // Scenario 5: coefficient write while busy is dropped and flagged.
        exp_q.push_back({18'd14, 18'd6});
        send(8'd2, 8'd1);
        coeff_addr = 2'd0; coeff_data = {8'd99, 8'd99}; coeff_wr_en = 1'b1;
        @(negedge clk);
        coeff_wr_en = 1'b0;
        chk("t5_err_set", 64'(cfg_err_o), 64'd1);
        send(8'd0, 8'd1); send(8'd1, 8'd1);
        recv("t5_cur");
        chk("t5_err_sticky", 64'(cfg_err_o), 64'd1);
        exp_q.push_back({18'd14, 18'd6});
        send(8'd2, 8'd1); send(8'd0, 8'd1); send(8'd1, 8'd1);
        recv("t5_next");
        chk("t5_err_sticky2", 64'(cfg_err_o), 64'd1);

        // Tap clamp: 7 requested, 4 used.
        wcoef(2'd3, 8'd1, 8'd7);
        cfg_taps = 3'd7;
        exp_q.push_back({18'd16, 18'd13});
        for (int i = 0; i < 4; i++) send(8'd1, 8'd1);
        recv("clamp");

        // Single-tap block goes straight to FLUSH.
        cfg_taps = 3'd1;
        exp_q.push_back({18'd12, 18'd5});
        send(8'd3, 8'd5);
        recv("taps1");

        // Scenario 6: asynchronous reset mid-ACCUM.
        cfg_taps = 3'd3;
        send(8'd2, 8'd1); send(8'd0, 8'd1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("t6_m_data",  64'(m_data_o),  64'd0);
        chk("t6_m_valid", 64'(m_valid_o), 64'd0);
        chk("t6_s_ready", 64'(s_ready_o), 64'd0);
        chk("t6_busy",    64'(busy_o),    64'd0);
        chk("t6_cfg_err", 64'(cfg_err_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_result", 64'(m_valid_o), 64'd0);
        exp_q.push_back({18'd0, 18'd0});
        send(8'd2, 8'd1); send(8'd0, 8'd1); send(8'd1, 8'd1);
        recv("t6_zero_coef");

        // Zero taps keeps the input closed.
        cfg_taps = 3'd0;
        repeat (2) @(negedge clk);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("zero_taps_ready", 64'(s_ready_o), 64'd0);
            chk("zero_taps_idle",  64'(busy_o),    64'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
